display_scan: RTL and testbench
===============================

// Module: display_scan
// PURPOSE
//  Display stage between current_time and sevenseg/shower. Snapshots time/date
//  fields once per frame, converts them serially to BCD (double-dabble), and
//  time-multiplexes 8 digits: digit code to sevenseg, active-low enables to
//  shower. Blanks the field being edited on a blink phase for time setting.
// PARAMETERS
//  SCAN_DIV      50000  clk cycles per digit slot (must be >= 80)
//  BLINK_FRAMES  64     frames per blink half-period (>= 1)
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous active-low reset
//  year        in   16  binary year
//  month       in   6   binary month
//  day         in   11  binary day
//  hour        in   11  binary hour
//  minute      in   11  binary minute
//  second      in   11  binary second
//  mode        in   1   0 = time HH-MM-SS, 1 = date YYYYMMDD
//  edit_field  in   2   0 none, 1 left, 2 middle, 3 right field blinks
//  digit_sel   out  3   index of the digit slot currently driven (7 = leftmost)
//  an          out  8   one-hot active-low digit enable, bit i = slot i
//  digit       out  4   code: 0-9 numeral, 4'hA dash, 4'hF blank
//  dp          out  1   decimal point, active-high
// BEHAVIOUR
//  Reset: digit_sel=0, an=8'hFF, digit=4'hF, dp=0, prescaler=0, blink
//   counter=0, blink phase=on, all BCD regs=0, converter FSM=IDLE.
//  Prescaler counts 0..SCAN_DIV-1; tick pulses on SCAN_DIV-1, then wraps to 0.
//  On tick: digit_sel <= digit_sel+1 (7 wraps to 0); an/digit/dp are registered
//   from the NEW slot on the same edge (single registered stage, no glitch).
//  Frame start = tick on which digit_sel wraps 7->0. On it: latch mode,
//   edit_field, and the 3 fields of the selected mode into shadow regs; FSM
//   leaves IDLE.
//  Clamp before conversion: 2-digit fields saturate at 99, year at 9999.
//  Converter FSM: IDLE -> LOAD(field k) -> SHIFT(16 cycles, add-3 then shift)
//   -> NEXT; after field 2 -> COMMIT -> IDLE. COMMIT copies all BCD digits to
//   the display regs in one cycle, so a frame never shows mixed old/new data.
//   Total conversion < 60 cycles, always finishes inside slot 0.
//  Frame start while FSM busy (cannot occur if SCAN_DIV >= 80): restart from
//   LOAD with the new snapshot; no COMMIT from the aborted run.
//  Time layout slots 7..0: H1 H0 A M1 M0 A S1 S0 (A = dash); dp=0 everywhere.
//   Fields: left=HH(7,6), middle=MM(4,3), right=SS(1,0); dashes never blank.
//  Date layout: Y3 Y2 Y1 Y0 M1 M0 D1 D0; dp=1 on slots 4 and 2.
//   Fields: left=YYYY(7-4), middle=MM(3,2), right=DD(1,0).
//  Leading zeros are shown (hour 5 -> "05").
//  Blink: counter increments each frame start; at BLINK_FRAMES-1 it wraps and
//   phase toggles. Phase off and slot in latched edit_field -> an stays 8'hFF
//   for that slot, digit=4'hF, dp=0. edit_field=0 -> never blank. Counter and
//   phase keep running regardless of edit_field.
//  Input changes mid-frame (including mode/edit_field) take effect only at the
//   next frame start plus conversion; the display lags inputs by <= 1 frame.
//  Reset asserted mid-frame: all regs to reset values immediately; first
//   frame after release shows zeros until the first COMMIT.
// TESTING
//  1 Reset with SCAN_DIV=100: an=8'hFF, digit=F; after release an walks
//    FE,FD,..,7F,FE at 100-cycle spacing, each change exactly on a tick edge.
//  2 mode=0, 12:34:56, edit 0: after 2nd frame slots 7..0 = 1,2,A,3,4,A,5,6,
//    dp=0 throughout.
//  3 mode=1, 2024/3/9: slots = 2,0,2,4,0,3,0,9; dp=1 only on slots 4, 2.
//  4 hour=150, year=12345: displays 99 and 9999 (clamp), no wrap.
//  5 BLINK_FRAMES=2, edit_field=2, mode 0: slots 4,3 alternate digit/blank every
//    2 frames; slots 7,6,5,2,1,0 never blank.
//  6 change second 58->59 mid-frame: the frame in progress shows 58 in all
//    slots; 59 appears from the next COMMIT; reset pulse mid-scan -> an=FF
//    at once, next frame after release shows zeros until COMMIT.

Source files
------------

// File: rtl/display_scan.sv
// Display scan stage: snapshots time/date once per frame, converts the fields
// to BCD serially, and multiplexes 8 digits with field blinking for editing.
module display_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] year,
  input  logic [5:0]  month,
  input  logic [10:0] day,
  input  logic [10:0] hour,
  input  logic [10:0] minute,
  input  logic [10:0] second,
  input  logic        mode,
  input  logic [1:0]  edit_field,
  output logic [2:0]  digit_sel,
  output logic [7:0]  an,
  output logic [3:0]  digit,
  output logic        dp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, NEXT, COMMIT} state_t;

  state_t      state, state_n;
  logic [PW-1:0] pre;
  logic [BW-1:0] blink_cnt;
  logic        phase_on;
  logic        tick, frame_start;

  logic        mode_r;
  logic [1:0]  edit_r;
  logic [13:0] snap0, snap1, snap2;
  logic [1:0]  fld;
  logic [3:0]  bit_cnt;
  logic [15:0] bin, bcd, bcd_adj;
  logic [15:0] conv0, disp0;
  logic [7:0]  conv1, conv2, disp1, disp2;

  assign tick        = (pre == PW'(SCAN_DIV - 1));
  assign frame_start = tick && (digit_sel == 3'd7);

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre       <= '0;
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      if (frame_start) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          phase_on  <= ~phase_on;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    for (int i = 0; i < 4; i++)
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = IDLE;
      LOAD:    state_n = SHIFT;
      SHIFT:   if (bit_cnt == 4'd15) state_n = NEXT;
      NEXT:    state_n = (fld == 2'd2) ? COMMIT : LOAD;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // A new frame always restarts the conversion with the fresh snapshot.
    if (frame_start) state_n = LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // NOTE: the BCD working and display registers are reset so the first frame
  // after reset shows a defined all-zero image rather than power-up garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r  <= 1'b0;
      edit_r  <= 2'd0;
      snap0   <= '0;
      snap1   <= '0;
      snap2   <= '0;
      fld     <= 2'd0;
      bit_cnt <= 4'd0;
      bin     <= '0;
      bcd     <= '0;
      conv0   <= '0;
      conv1   <= '0;
      conv2   <= '0;
      disp0   <= '0;
      disp1   <= '0;
      disp2   <= '0;
    end else if (frame_start) begin
      mode_r <= mode;
      edit_r <= edit_field;
      fld    <= 2'd0;
      if (mode) begin
        snap0 <= (year > 16'd9999) ? 14'd9999 : year[13:0];
        snap1 <= {8'd0, month};
        snap2 <= (day > 11'd99) ? 14'd99 : {3'd0, day};
      end else begin
        snap0 <= (hour > 11'd99) ? 14'd99 : {3'd0, hour};
        snap1 <= (minute > 11'd99) ? 14'd99 : {3'd0, minute};
        snap2 <= (second > 11'd99) ? 14'd99 : {3'd0, second};
      end
    end else begin
      case (state)
        LOAD: begin
          bcd     <= '0;
          bit_cnt <= 4'd0;
          case (fld)
            2'd0:    bin <= {2'b00, snap0};
            2'd1:    bin <= {2'b00, snap1};
            default: bin <= {2'b00, snap2};
          endcase
        end
        SHIFT: begin
          bcd     <= {bcd_adj[14:0], bin[15]};
          bin     <= {bin[14:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
        end
        NEXT: begin
          case (fld)
            2'd0:    conv0 <= bcd;
            2'd1:    conv1 <= bcd[7:0];
            default: conv2 <= bcd[7:0];
          endcase
          fld <= fld + 2'd1;
        end
        COMMIT: begin
          disp0 <= conv0;
          disp1 <= conv1;
          disp2 <= conv2;
        end
        default: ;
      endcase
    end
  end

  logic [2:0] ns;
  logic [3:0] slot_code;
  logic [1:0] slot_fld;
  logic       slot_dp, blank;

  // Decode of the slot about to be driven; registered on the tick edge.
  always_comb begin
    ns        = digit_sel + 3'd1;
    slot_code = 4'hF;
    slot_fld  = 2'd0;
    slot_dp   = 1'b0;
    if (mode_r) begin
      case (ns)
        3'd7: begin slot_code = disp0[15:12]; slot_fld = 2'd1; end
        3'd6: begin slot_code = disp0[11:8];  slot_fld = 2'd1; end
        3'd5: begin slot_code = disp0[7:4];   slot_fld = 2'd1; end
        3'd4: begin slot_code = disp0[3:0];   slot_fld = 2'd1; slot_dp = 1'b1; end
        3'd3: begin slot_code = disp1[7:4];   slot_fld = 2'd2; end
        3'd2: begin slot_code = disp1[3:0];   slot_fld = 2'd2; slot_dp = 1'b1; end
        3'd1: begin slot_code = disp2[7:4];   slot_fld = 2'd3; end
        default: begin slot_code = disp2[3:0]; slot_fld = 2'd3; end
      endcase
    end else begin
      case (ns)
        3'd7: begin slot_code = disp0[7:4]; slot_fld = 2'd1; end
        3'd6: begin slot_code = disp0[3:0]; slot_fld = 2'd1; end
        3'd5: slot_code = 4'hA;
        3'd4: begin slot_code = disp1[7:4]; slot_fld = 2'd2; end
        3'd3: begin slot_code = disp1[3:0]; slot_fld = 2'd2; end
        3'd2: slot_code = 4'hA;
        3'd1: begin slot_code = disp2[7:4]; slot_fld = 2'd3; end
        default: begin slot_code = disp2[3:0]; slot_fld = 2'd3; end
      endcase
    end
    blank = !phase_on && (edit_r != 2'd0) && (slot_fld == edit_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel <= 3'd0;
      an        <= 8'hFF;
      digit     <= 4'hF;
      dp        <= 1'b0;
    end else if (tick) begin
      digit_sel <= ns;
      if (blank) begin
        an    <= 8'hFF;
        digit <= 4'hF;
        dp    <= 1'b0;
      end else begin
        an    <= ~(8'd1 << ns);
        digit <= slot_code;
        dp    <= slot_dp;
      end
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan: expected digit slots are queued from a
// decimal model of the display and compared as the scan reaches each slot.
module tb_display_scan;

  localparam int SD = 100;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] year;
  logic [5:0]  month;
  logic [10:0] day, hour, minute, second;
  logic        mode;
  logic [1:0]  edit_field;
  logic [2:0]  digit_sel;
  logic [7:0]  an;
  logic [3:0]  digit;
  logic        dp;

  display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .year(year), .month(month), .day(day),
    .hour(hour), .minute(minute), .second(second), .mode(mode),
    .edit_field(edit_field), .digit_sel(digit_sel), .an(an), .digit(digit), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] an;
    logic [3:0] digit;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int exp_sel = 0;
  int fs_cnt  = 0;
  int cyc;
  bit m_s;
  int f0_s, f1_s, f2_s, ed_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit phase_on(input int k);
    return ((k / BF) % 2) == 0;
  endfunction

  function automatic int clampv(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // Queue the expected image for slots 1..7 then slot 0 of the coming window.
  function automatic void push_window(input bit m, input int f0, input int f1,
                                      input int f2, input int ed, input bit ph);
    int c0, c1, c2;
    int d[8];
    int fl[8];
    bit p[8];
    c0 = m ? clampv(f0, 9999) : clampv(f0, 99);
    c1 = clampv(f1, 99);
    c2 = clampv(f2, 99);
    for (int s = 0; s < 8; s++) p[s] = 1'b0;
    if (m) begin
      d[7] = c0 / 1000; d[6] = (c0 / 100) % 10; d[5] = (c0 / 10) % 10; d[4] = c0 % 10;
      fl[7] = 1; fl[6] = 1; fl[5] = 1; fl[4] = 1;
      p[4] = 1'b1; p[2] = 1'b1;
    end else begin
      d[7] = c0 / 10; d[6] = c0 % 10; d[5] = 10; d[4] = c1 / 10;
      fl[7] = 1; fl[6] = 1; fl[5] = 0; fl[4] = 2;
    end
    d[3] = c1 % 10;
    d[2] = m ? c1 / 10 : 10;
    if (m) begin d[3] = c1 / 10; d[2] = c1 % 10; end
    fl[3] = 2; fl[2] = m ? 2 : 0;
    d[1] = c2 / 10; d[0] = c2 % 10;
    fl[1] = 3; fl[0] = 3;
    for (int i = 1; i <= 8; i++) begin
      int s;
      exp_t e;
      s = i % 8;
      e.sel = 3'(s);
      if (!ph && ed != 0 && fl[s] == ed) begin
        e.an = 8'hFF; e.digit = 4'hF; e.dp = 1'b0;
      end else begin
        e.an = ~(8'd1 << s); e.digit = 4'(d[s]); e.dp = p[s];
      end
      sb.push_back(e);
    end
  endfunction

  task automatic run_slot(output int n);
    logic [2:0] prev;
    bit seen;
    exp_t e;
    prev = digit_sel;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 3 * SD && !seen; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (digit_sel !== prev) seen = 1'b1;
    end
    check("tick_timeout", 32'(seen), 32'd1);
    exp_sel = (exp_sel + 1) % 8;
    if (exp_sel == 0) fs_cnt++;
    check("digit_sel", 32'(digit_sel), 32'(exp_sel));
    if (sb.size() > 0 && 32'(sb[0].sel) == 32'(exp_sel)) begin
      e = sb.pop_front();
      check($sformatf("an_slot%0d_fs%0d", exp_sel, fs_cnt), 32'(an), 32'(e.an));
      check($sformatf("digit_slot%0d_fs%0d", exp_sel, fs_cnt), 32'(digit), 32'(e.digit));
      check($sformatf("dp_slot%0d_fs%0d", exp_sel, fs_cnt), 32'(dp), 32'(e.dp));
    end
  endtask

  task automatic set_inputs(input bit m, input int f0, input int f1, input int f2, input int ed);
    if (m) begin
      year = 16'(f0); month = 6'(f1); day = 11'(f2);
    end else begin
      hour = 11'(f0); minute = 11'(f1); second = 11'(f2);
    end
    mode = m;
    edit_field = 2'(ed);
    m_s = m; f0_s = f0; f1_s = f1; f2_s = f2; ed_s = ed;
  endtask

  // Window opened by the current frame start, using the inputs already held.
  task automatic expect_same();
    int n;
    push_window(m_s, f0_s, f1_s, f2_s, ed_s, phase_on(fs_cnt));
    for (int i = 0; i < 8; i++) run_slot(n);
  endtask

  // Inputs changed now are snapshotted at the next frame start.
  task automatic expect_window();
    int n;
    do run_slot(n); while (exp_sel != 0);
    expect_same();
  endtask

  initial begin
    rst_n = 1'b0;
    year = '0; month = '0; day = '0; hour = '0; minute = '0; second = '0;
    mode = 1'b0; edit_field = 2'd0;
    set_inputs(0, 12, 34, 56, 0);
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hFF);
    check("rst_digit", 32'(digit), 32'hF);
    check("rst_dp", 32'(dp), 32'd0);
    check("rst_sel", 32'(digit_sel), 32'd0);
    rst_n = 1'b1;

    // First frame out of reset shows zeros; each slot change 100 cycles apart.
    push_window(0, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run_slot(cyc);
      check($sformatf("tick_spacing_%0d", i), 32'(cyc), 32'(SD));
    end

    expect_window();                          // 12-34-56
    set_inputs(1, 2024, 3, 9, 0);  expect_window();
    set_inputs(0, 150, 7, 0, 0);   expect_window();
    set_inputs(1, 12345, 12, 31, 0); expect_window();
    set_inputs(0, 99, 100, 2047, 0); expect_window();
    set_inputs(1, 0, 63, 2047, 0); expect_window();

    // Blinking of each field across consecutive frames.
    set_inputs(0, 12, 34, 56, 2); expect_window();
    expect_same(); expect_same(); expect_same();
    set_inputs(1, 2024, 3, 9, 1); expect_window();
    expect_same(); expect_same();
    set_inputs(0, 1, 2, 3, 3); expect_window();
    expect_same(); expect_same();

    // Mid-frame input change only shows from the following window.
    set_inputs(0, 23, 59, 58, 0); expect_window();
    push_window(0, 23, 59, 58, 0, phase_on(fs_cnt));
    for (int i = 0; i < 3; i++) run_slot(cyc);
    set_inputs(0, 23, 59, 59, 0);
    for (int i = 0; i < 5; i++) run_slot(cyc);
    expect_same();

    // Reset pulse in the middle of a scan.
    for (int i = 0; i < 3; i++) run_slot(cyc);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_an", 32'(an), 32'hFF);
    check("midrst_digit", 32'(digit), 32'hF);
    check("midrst_sel", 32'(digit_sel), 32'd0);
    check("midrst_dp", 32'(dp), 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    exp_sel = 0;
    fs_cnt = 0;
    sb.delete();
    push_window(0, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 8; i++) run_slot(cyc);
    expect_window();

    check("queue_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
